// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   state_t  : arbiter FSM states (IDLE, GRANT, GAP)
//   NUM_REQ  : number of requesters
//   IDX_W    : width of a requester index
//   onehot() : enabled 2-to-4 decode of a requester index
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between up to four masters and the arbiter.
//   en        : global arbiter enable (masters side drives)
//   req[3:0]  : per-master request, held high for the whole transaction
//   gnt[3:0]  : registered one-hot grant
//   gnt_idx   : index of current or last winner
//   gnt_valid : OR of gnt
//   timeout   : one-cycle pulse on the final cycle of a force-released grant
//
// Handshake: a master raises req[i] and keeps it high; it owns the resource
// for every cycle gnt[i] is high and releases it by dropping req[i]. The
// arbiter never grants two masters at once and always inserts one idle
// cycle (gnt = 0000) between consecutive grants.
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin pick over four eligible requesters.
//   eligible[3:0] : candidates this cycle
//   ptr[1:0]      : highest-priority index
//   any           : at least one candidate
//   win_idx[1:0]  : first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
// Rotate so ptr lands at bit 0, take the lowest set bit, then add ptr back.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   win_idx
);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     off;

  assign doubled = {eligible, eligible};
  assign rot     = doubled[ptr +: NUM_REQ];

  always_comb begin
    off = '0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
  end

  assign any     = |eligible;
  assign win_idx = ptr + off;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with hold timeout and global enable.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : request/grant bundle (slave side)
//   dbg_state : current FSM state, for observation only
// Parameters:
//   HOLD_MAX  : max cycles a grant may be held (0 disables the timeout)
//   CNT_W     : hold-counter width, HOLD_MAX <= 2**CNT_W - 1
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_arbiter4_if.slave         bus,
  output state_t               dbg_state
);

  localparam bit               HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] mask_q, mask_d, mask_set;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic [NUM_REQ-1:0] gnt_q;

  logic [NUM_REQ-1:0] eligible;
  logic               any;
  logic [IDX_W-1:0]   win_idx;
  logic               hold_expire;

  assign eligible = bus.req & ~mask_q & {NUM_REQ{bus.en}};

  rr_pick4 u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .any      (any),
    .win_idx  (win_idx)
  );

  // Forced release happens on the last cycle a grant is held; it only counts
  // when neither the enable drop nor a normal release wins that same edge.
  assign hold_expire = HOLD_EN && (state_q == GRANT) && bus.en &&
                       bus.req[idx_q] && (cnt_q == HOLD_LAST);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    valid_d  = 1'b0;
    mask_set = '0;
    case (state_q)
      IDLE, GAP: begin
        if (any) begin
          state_d = GRANT;
          idx_d   = win_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        if (!bus.en) begin
          state_d = IDLE;
          ptr_d   = idx_q + 1'b1;
        end else if (!bus.req[idx_q]) begin
          state_d = GAP;
          ptr_d   = idx_q + 1'b1;
        end else if (hold_expire) begin
          state_d  = GAP;
          ptr_d    = idx_q + 1'b1;
          mask_set = onehot(idx_q);
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A set bit always has req high, so clearing by ~req never fights the set.
  assign mask_d = (mask_q & bus.req) | mask_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      gnt_q   <= valid_d ? onehot(idx_d) : '0;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = hold_expire;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with HOLD_MAX = 3.
module tb_rr_arbiter4;
  import arb_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] exp_q[$];

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.HOLD_MAX(3), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_gnt,
                           input logic [1:0] e_idx, input logic e_to);
    check({tag, ".gnt"},       32'(bus.gnt),       32'(e_gnt));
    check({tag, ".gnt_idx"},   32'(bus.gnt_idx),   32'(e_idx));
    check({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(e_gnt != 4'b0000));
    check({tag, ".timeout"},   32'(bus.timeout),   32'(e_to));
  endtask

  // Expected per-cycle grants for the timeout hand-off scenario.
  logic [3:0] t4_gnt[10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000,
                             4'b0010, 4'b0010, 4'b0010, 4'b0000,
                             4'b0000, 4'b0000};
  logic [1:0] t4_idx[10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
  logic       t4_to[10]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    logic [3:0] e;
    logic [1:0] ei;

    // ---- reset state ----
    do_reset();
    check_out("reset", 4'b0000, 2'd0, 1'b0);
    check("reset.state", 32'(dbg_state), 32'(IDLE));

    // ---- 1: single request, one-cycle latency, release ----
    bus.en  = 1'b1;
    bus.req = 4'b0100;
    tick();
    check_out("single.grant", 4'b0100, 2'd2, 1'b0);
    check("single.state", 32'(dbg_state), 32'(GRANT));
    bus.req = 4'b0000;
    tick();
    check_out("single.gap", 4'b0000, 2'd2, 1'b0);
    tick();
    check_out("single.idle", 4'b0000, 2'd2, 1'b0);
    check("single.idle_state", 32'(dbg_state), 32'(IDLE));

    // ---- 2: round-robin fairness, 2-cycle holds ----
    do_reset();
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    bus.en  = 1'b1;
    bus.req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      e  = exp_q.pop_front();
      ei = e[1:0];
      check_out("rr.grant", onehot(ei), ei, 1'b0);
      tick();
      check_out("rr.hold", onehot(ei), ei, 1'b0);
      bus.req[ei] = 1'b0;
      tick();
      check_out("rr.gap", 4'b0000, ei, 1'b0);
      bus.req[ei] = 1'b1;
      tick();
    end

    // ---- 3: timeout on a single persistent requester ----
    do_reset();
    bus.en  = 1'b1;
    bus.req = 4'b0001;
    tick();
    check_out("to.c0", 4'b0001, 2'd0, 1'b0);
    tick();
    check_out("to.c1", 4'b0001, 2'd0, 1'b0);
    tick();
    check_out("to.c2", 4'b0001, 2'd0, 1'b1);
    tick();
    check_out("to.gap", 4'b0000, 2'd0, 1'b0);
    tick();
    check_out("to.masked0", 4'b0000, 2'd0, 1'b0);
    tick();
    check_out("to.masked1", 4'b0000, 2'd0, 1'b0);
    bus.req = 4'b0000;
    tick();
    check_out("to.dropped", 4'b0000, 2'd0, 1'b0);
    bus.req = 4'b0001;
    tick();
    check_out("to.regrant", 4'b0001, 2'd0, 1'b0);

    // ---- 4: timeout hand-off between two holders ----
    do_reset();
    bus.en  = 1'b1;
    bus.req = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_out($sformatf("handoff.c%0d", c), t4_gnt[c], t4_idx[c], t4_to[c]);
    end
    bus.req = 4'b0010;
    tick();
    check_out("handoff.drop0", 4'b0000, 2'd1, 1'b0);
    bus.req = 4'b0011;
    tick();
    check_out("handoff.regrant0", 4'b0001, 2'd0, 1'b0);

    // ---- 5: enable drop mid-grant ----
    do_reset();
    bus.en  = 1'b1;
    bus.req = 4'b1000;
    tick();
    check_out("en.grant3", 4'b1000, 2'd3, 1'b0);
    bus.en = 1'b0;
    tick();
    check_out("en.off", 4'b0000, 2'd3, 1'b0);
    check("en.off_state", 32'(dbg_state), 32'(IDLE));
    bus.en  = 1'b1;
    bus.req = 4'b1001;
    tick();
    check_out("en.wrap0", 4'b0001, 2'd0, 1'b0);

    // ---- 6: asynchronous reset mid-grant ----
    do_reset();
    bus.en  = 1'b1;
    bus.req = 4'b0010;
    tick();
    check_out("arst.grant1", 4'b0010, 2'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_out("arst.asserted", 4'b0000, 2'd0, 1'b0);
    check("arst.state", 32'(dbg_state), 32'(IDLE));
    #2 rst_n = 1'b1;
    bus.req = 4'b1111;
    tick();
    check_out("arst.first", 4'b0001, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
Four-requester round-robin arbiter that shares one resource, such as a bus slot or write port.
- Decides a 2-bit winner index and drives a registered one-hot grant, the enabled 2-to-4 decode of that index.
- Sits between up to four masters and the shared resource.
- Adds fairness, a per-grant hold timeout and a global enable. Grants are all-zero when the enable is low.

Parameters:
- HOLD_MAX, default 15: maximum cycles a grant may be held before forced release. 0 disables the timeout.
- CNT_W, default 4: hold-counter width. Requirement: HOLD_MAX <= 2^CNT_W - 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  arbiter enable. Low forces grants off.
- req  in  4  request per master. Held high for the whole transaction.
- gnt  out  4  registered one-hot grant. 0000 when no grant.
- gnt_idx  out  2  binary index of the current or last winner
- gnt_valid  out  1  high while a grant is active. Equals OR of gnt.
- timeout  out  1  one-cycle pulse when a grant is force-released

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, ptr = 0, mask = 0000, cnt = 0.
  - gnt = 0000, gnt_idx = 00, gnt_valid = 0, timeout = 0.
- Reset mid-grant drops gnt immediately, with no timeout pulse.
- Encoding invariants:
  - gnt == (gnt_valid ? onehot(gnt_idx) : 0000), never more than one bit set.
  - gnt_idx holds the last winner while gnt_valid = 0.
- eligible = req & ~mask & {4{en}}.
- Pick rule: first set bit of eligible, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- States: IDLE, GRANT, GAP.
- IDLE:
  - eligible != 0 at edge N -> GRANT.
  - At N+1: gnt_idx = winner, gnt = onehot(winner), gnt_valid = 1, cnt = 0.
  - Request-to-grant latency: 1 cycle.
- GRANT, cnt increments each cycle. Exit conditions, in priority order:
  1. en = 0 -> IDLE, gnt = 0000 next cycle, no timeout pulse.
  2. req[gnt_idx] = 0 -> GAP (normal release).
  3. HOLD_MAX != 0 and cnt == HOLD_MAX-1 -> GAP, timeout = 1 for one cycle, mask[gnt_idx] set.
  - Every exit from GRANT sets ptr = gnt_idx + 1 (2-bit wrap, 3 -> 0).
  - Resulting hold length: at most HOLD_MAX cycles with gnt high.
- GAP:
  - gnt = 0000 for exactly one cycle. This is a mandatory turnaround with no back-to-back grants.
  - Same edge arbitrates: eligible != 0 -> GRANT with the new winner, else IDLE.
- Mask rules:
  - mask[i] clears on any cycle where req[i] = 0.
  - A timed-out master must drop req for at least one cycle before it can win again.
  - Clear takes priority over set only for different bits. A bit is never set and cleared in the same cycle, because set requires req[i] = 1.
- Simultaneous events:
  - All four requesting: grants cycle in ptr order.
  - The current holder re-requesting in GAP has lowest priority, because ptr has advanced past it.
- Counter arithmetic: cnt saturates at 2^CNT_W - 1 when HOLD_MAX = 0. It has no wrap effect.
- en low in IDLE or GAP: no arbitration, state -> IDLE. ptr and mask are retained.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, GRANT, GAP}
  - NUM_REQ = 4, IDX_W = 2
- Sub-module rr_pick4, combinational:
  - Inputs: eligible[3:0], ptr[1:0].
  - Outputs: any, win_idx[1:0].
  - Implemented as rotate, fixed-priority pick, un-rotate.
- Top level holds: FSM, cnt, ptr, mask, and the output registers with the one-hot decode of the next gnt_idx.

Test Plan:
1. Reset then single request: rst_n low->high, en = 1, req = 0100 at cycle 0 -> gnt = 0100, gnt_idx = 2, gnt_valid = 1 at cycle 1. Drop req -> gnt = 0000 the cycle after the drop.
2. Round-robin fairness: req = 1111, each master releases after 2 cycles -> grant order 0, 1, 2, 3, 0. Exactly one GAP cycle (gnt = 0000) between grants.
3. Timeout: HOLD_MAX = 3, req = 0001 held forever -> gnt = 0001 for 3 cycles, timeout pulses on the final grant cycle. Master 0 is not regranted until req[0] drops for one cycle, then regranted.
4. Timeout hand-off: HOLD_MAX = 3, req = 0011 held -> grant 0 (3 cycles), GAP, grant 1 (3 cycles), GAP, grant 0 only after req[0] toggles low.
5. Enable drop mid-grant: gnt = 1000, en -> 0 -> gnt = 0000 next cycle, timeout = 0. en -> 1 with req = 1001 -> master 0 wins (ptr = 0 after wrap from 3).
6. Async reset mid-grant: assert rst_n between edges while gnt = 0010 -> all outputs zero immediately. After release, req = 1111 -> master 0 is granted first.
